eth_rx_arp_parser: RTL and testbench

//  Receive-side ARP frame parser. Sits on the GMII RX byte stream (i_rx_clk

---
 rtl/eth_rx_arp_parser.sv | 263 ++++++++++++++++++++++++++
 tb/tb_eth_rx_arp_parser.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_arp_parser.sv
// Receive-side ARP parser on the GMII RX byte stream: strips preamble/SFD, filters on
// destination MAC, decodes ARP fields, checks the FCS and holds one frame for the host.
module eth_rx_arp_parser #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic        rst_n,
    input  logic        i_rx_clk,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_dv,
    input  logic [47:0] i_my_mac,
    input  logic [2:0]  i_rd_addr,
    output logic [31:0] o_rd_data,
    input  logic        i_ack,
    output logic        o_pkt_valid,
    output logic [1:0]  o_pkt_type,
    output logic        o_pkt_stb
);
    localparam int          CNT_W       = $clog2(MAX_FRAME + 2);
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_HEADER,
        S_WAIT_END,
        S_CHECK
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [31:0]      crc_q, crc_d;
    logic             past_sfd_q, past_sfd_d;
    logic             mac_bc_q, mac_bc_d;
    logic             mac_uc_q, mac_uc_d;
    logic [1:0]       oper_q, oper_d;
    logic [47:0]      sha_sh_q, sha_sh_d;
    logic [31:0]      spa_sh_q, spa_sh_d;
    logic [47:0]      tha_sh_q, tha_sh_d;
    logic [31:0]      tpa_sh_q, tpa_sh_d;
    logic [47:0]      sha_q, sha_d;
    logic [31:0]      spa_q, spa_d;
    logic [47:0]      tha_q, tha_d;
    logic [31:0]      tpa_q, tpa_d;
    logic             valid_q, valid_d;
    logic [1:0]       type_q, type_d;
    logic             stb_q, stb_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [7:0]       ovf_cnt_q, ovf_cnt_d;

    logic [7:0]       my_mac_byte [8];
    logic             low_off;
    logic [5:0]       off;
    logic             frame_good;
    logic             commit;
    logic             field_bad;

    // Wire order: byte 0 on the wire is the most significant MAC byte.
    for (genvar gi = 0; gi < 8; gi++) begin : g_mac_byte
        if (gi < 6) begin : g_real
            assign my_mac_byte[gi] = i_my_mac[47-8*gi -: 8];
        end else begin : g_pad
            assign my_mac_byte[gi] = 8'h00;
        end
    end

    // MSB-first register fed LSB-first data bits; equivalent to the reflected Ethernet CRC.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
            else                 c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    assign low_off    = (byte_cnt_q < CNT_W'(64));
    assign off        = byte_cnt_q[5:0];
    assign frame_good = (byte_cnt_q >= CNT_W'(MIN_FRAME)) &&
                        (byte_cnt_q <= CNT_W'(MAX_FRAME)) &&
                        (crc_q == CRC_RESIDUE);
    assign commit     = (state_q == S_CHECK) && frame_good && !valid_q;

    always_ff @(posedge i_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            crc_q      <= '0;
            past_sfd_q <= 1'b0;
            mac_bc_q   <= 1'b0;
            mac_uc_q   <= 1'b0;
            oper_q     <= '0;
            sha_sh_q   <= '0;
            spa_sh_q   <= '0;
            tha_sh_q   <= '0;
            tpa_sh_q   <= '0;
            sha_q      <= '0;
            spa_q      <= '0;
            tha_q      <= '0;
            tpa_q      <= '0;
            valid_q    <= 1'b0;
            type_q     <= '0;
            stb_q      <= 1'b0;
            drop_cnt_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            past_sfd_q <= past_sfd_d;
            mac_bc_q   <= mac_bc_d;
            mac_uc_q   <= mac_uc_d;
            oper_q     <= oper_d;
            sha_sh_q   <= sha_sh_d;
            spa_sh_q   <= spa_sh_d;
            tha_sh_q   <= tha_sh_d;
            tpa_sh_q   <= tpa_sh_d;
            sha_q      <= sha_d;
            spa_q      <= spa_d;
            tha_q      <= tha_d;
            tpa_q      <= tpa_d;
            valid_q    <= valid_d;
            type_q     <= type_d;
            stb_q      <= stb_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        past_sfd_d = past_sfd_q;
        mac_bc_d   = mac_bc_q;
        mac_uc_d   = mac_uc_q;
        oper_d     = oper_q;
        sha_sh_d   = sha_sh_q;
        spa_sh_d   = spa_sh_q;
        tha_sh_d   = tha_sh_q;
        tpa_sh_d   = tpa_sh_q;
        sha_d      = sha_q;
        spa_d      = spa_q;
        tha_d      = tha_q;
        tpa_d      = tpa_q;
        valid_d    = valid_q;
        type_d     = type_q;
        stb_d      = 1'b0;
        drop_cnt_d = drop_cnt_q;
        ovf_cnt_d  = ovf_cnt_q;
        field_bad  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_rx_dv) begin
                    past_sfd_d = 1'b0;
                    state_d    = (i_rx_data == 8'h55) ? S_PREAMBLE : S_WAIT_END;
                end
            end
            S_PREAMBLE: begin
                if (!i_rx_dv) begin
                    state_d = S_IDLE;
                end else if (i_rx_data == 8'hD5) begin
                    state_d    = S_HEADER;
                    byte_cnt_d = '0;
                    crc_d      = 32'hFFFF_FFFF;
                    past_sfd_d = 1'b1;
                    mac_bc_d   = 1'b1;
                    mac_uc_d   = 1'b1;
                    oper_d     = '0;
                end else if (i_rx_data != 8'h55) begin
                    state_d = S_WAIT_END;
                end
            end
            S_HEADER: begin
                if (!i_rx_dv) begin
                    state_d = S_CHECK;
                end else begin
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    crc_d      = crc32_byte(crc_q, i_rx_data);
                    if (low_off) begin
                        case (off)
                            6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: begin
                                mac_bc_d  = mac_bc_q & (i_rx_data == 8'hFF);
                                mac_uc_d  = mac_uc_q & (i_rx_data == my_mac_byte[off[2:0]]);
                                field_bad = !(mac_bc_d | mac_uc_d);
                            end
                            6'd12:   field_bad = (i_rx_data != 8'h08);
                            6'd13:   field_bad = (i_rx_data != 8'h06);
                            6'd14:   field_bad = (i_rx_data != 8'h00);
                            6'd15:   field_bad = (i_rx_data != 8'h01);
                            6'd16:   field_bad = (i_rx_data != 8'h08);
                            6'd17:   field_bad = (i_rx_data != 8'h00);
                            6'd18:   field_bad = (i_rx_data != 8'h06);
                            6'd19:   field_bad = (i_rx_data != 8'h04);
                            6'd20:   field_bad = (i_rx_data != 8'h00);
                            6'd21: begin
                                field_bad = (i_rx_data != 8'h01) && (i_rx_data != 8'h02);
                                oper_d    = i_rx_data[1:0];
                            end
                            default: field_bad = 1'b0;
                        endcase
                        if (off >= 6'd22 && off <= 6'd27) sha_sh_d = {sha_sh_q[39:0], i_rx_data};
                        if (off >= 6'd28 && off <= 6'd31) spa_sh_d = {spa_sh_q[23:0], i_rx_data};
                        if (off >= 6'd32 && off <= 6'd37) tha_sh_d = {tha_sh_q[39:0], i_rx_data};
                        if (off >= 6'd38 && off <= 6'd41) tpa_sh_d = {tpa_sh_q[23:0], i_rx_data};
                    end
                    if (field_bad || (byte_cnt_d > CNT_W'(MAX_FRAME))) state_d = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                if (!i_rx_dv) begin
                    state_d = S_IDLE;
                    if (past_sfd_q) drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (!frame_good) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end else if (valid_q) begin
                    ovf_cnt_d = ovf_cnt_q + 8'd1;
                end else begin
                    sha_d   = sha_sh_q;
                    spa_d   = spa_sh_q;
                    tha_d   = tha_sh_q;
                    tpa_d   = tpa_sh_q;
                    valid_d = 1'b1;
                    type_d  = oper_q;
                    stb_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A capture in the same cycle as an ack takes priority so the new frame is not lost.
        if (i_ack && !commit) begin
            valid_d = 1'b0;
            type_d  = '0;
        end
    end

    always_comb begin
        o_pkt_valid = valid_q;
        o_pkt_type  = type_q;
        o_pkt_stb   = stb_q;
        o_rd_data   = '0;
        case (i_rd_addr)
            3'd0: o_rd_data = sha_q[47:16];
            3'd1: o_rd_data = {sha_q[15:0], 16'h0000};
            3'd2: o_rd_data = spa_q;
            3'd3: o_rd_data = tha_q[47:16];
            3'd4: o_rd_data = {tha_q[15:0], 16'h0000};
            3'd5: o_rd_data = tpa_q;
            3'd6: o_rd_data = {30'h0, type_q};
            3'd7: o_rd_data = {16'h0000, ovf_cnt_q, drop_cnt_q};
            default: o_rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_eth_rx_arp_parser.sv
// Directed bench for eth_rx_arp_parser: builds ARP frames with a reference FCS,
// plays them on the GMII side and checks strobe timing, capture, readback and counters.
module tb_eth_rx_arp_parser;
    localparam logic [47:0] MY_MAC = 48'h02_00_5E_10_20_30;
    localparam logic [47:0] BCAST  = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] SHA_A  = 48'h00_11_22_33_44_55;
    localparam logic [47:0] SHA_B  = 48'hAA_BB_CC_DD_EE_01;

    logic        rx_clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_dv;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        ack;
    logic        pkt_valid;
    logic [1:0]  pkt_type;
    logic        pkt_stb;

    int checks   = 0;
    int failures = 0;
    int frame_no = 0;
    logic [7:0] frm[$];

    always #5 rx_clk = ~rx_clk;

    eth_rx_arp_parser dut (
        .rst_n      (rst_n),
        .i_rx_clk   (rx_clk),
        .i_rx_data  (rx_data),
        .i_rx_dv    (rx_dv),
        .i_my_mac   (MY_MAC),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .i_ack      (ack),
        .o_pkt_valid(pkt_valid),
        .o_pkt_type (pkt_type),
        .o_pkt_stb  (pkt_stb)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic rd_check(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        rd_addr = addr;
        #1;
        check_eq(tag, rd_data, exp);
    endtask

    task automatic drive_byte(input logic [7:0] b);
        @(posedge rx_clk); #1;
        rx_dv   = 1'b1;
        rx_data = b;
    endtask

    task automatic push_be(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
    endtask

    // Reference FCS: standard reflected CRC-32, complemented, sent low byte first.
    task automatic append_fcs();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (frm[i]) begin
            c = c ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    task automatic build_arp(input logic [47:0] dst, input logic [15:0] etype,
                             input logic [15:0] oper, input logic [47:0] sha,
                             input logic [31:0] spa, input logic [47:0] tha,
                             input logic [31:0] tpa, input int body_len);
        frm.delete();
        push_be(dst, 6);
        push_be(sha, 6);
        push_be({32'h0, etype}, 2);
        push_be(48'h0001, 2);
        push_be(48'h0800, 2);
        frm.push_back(8'h06);
        frm.push_back(8'h04);
        push_be({32'h0, oper}, 2);
        push_be(sha, 6);
        push_be({16'h0, spa}, 4);
        push_be(tha, 6);
        push_be({16'h0, tpa}, 4);
        while (frm.size() < body_len) frm.push_back(8'h00);
        append_fcs();
    endtask

    // Strobe is expected exactly two cycles after the first dv=0 cycle.
    task automatic send_frame(input logic exp_stb, input logic ack_at_commit);
        for (int i = 0; i < 7; i++) drive_byte(8'h55);
        drive_byte(8'hD5);
        foreach (frm[i]) drive_byte(frm[i]);
        @(posedge rx_clk); #1;
        rx_dv   = 1'b0;
        rx_data = 8'h00;
        @(posedge rx_clk); #1;
        if (ack_at_commit) ack = 1'b1;
        @(negedge rx_clk);
        check_eq("stb_early", {31'h0, pkt_stb}, 32'h0);
        @(posedge rx_clk); #1;
        ack = 1'b0;
        @(negedge rx_clk);
        check_eq("stb_pulse", {31'h0, pkt_stb}, {31'h0, exp_stb});
        @(posedge rx_clk);
        @(negedge rx_clk);
        check_eq("stb_off", {31'h0, pkt_stb}, 32'h0);
        frame_no++;
        $display("frame %0d: %0d bytes stb=%0b valid=%0b type=%0d",
                 frame_no, frm.size(), exp_stb, pkt_valid, pkt_type);
    endtask

    task automatic send_short_bad();
        drive_byte(8'h55);
        drive_byte(8'hD5);
        drive_byte(8'h00);
        @(posedge rx_clk); #1;
        rx_dv = 1'b0;
        @(posedge rx_clk); #1;
        frame_no++;
        $display("frame %0d: short bad-dst frame", frame_no);
    endtask

    task automatic pulse_ack();
        @(posedge rx_clk); #1;
        ack = 1'b1;
        @(posedge rx_clk); #1;
        ack = 1'b0;
        @(negedge rx_clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n   = 1'b0;
        rx_dv   = 1'b0;
        rx_data = 8'h00;
        rd_addr = 3'd0;
        ack     = 1'b0;
        repeat (3) @(posedge rx_clk);
        @(negedge rx_clk);
        check_eq("rst_valid", {31'h0, pkt_valid}, 32'h0);
        check_eq("rst_type", {30'h0, pkt_type}, 32'h0);
        check_eq("rst_stb", {31'h0, pkt_stb}, 32'h0);
        rd_check(3'd7, 32'h0, "rst_counters");
        rd_check(3'd0, 32'h0, "rst_sha_hi");
        @(posedge rx_clk); #1;
        rst_n = 1'b1;

        // Broadcast request
        build_arp(BCAST, 16'h0806, 16'h0001, SHA_A, 32'hC0A8010A, 48'h0, 32'hC0A80101, 60);
        send_frame(1'b1, 1'b0);
        check_eq("t1_valid", {31'h0, pkt_valid}, 32'h1);
        check_eq("t1_type", {30'h0, pkt_type}, 32'h1);
        rd_check(3'd2, 32'hC0A8010A, "t1_spa");
        rd_check(3'd0, 32'h00112233, "t1_sha_hi");
        rd_check(3'd1, 32'h44550000, "t1_sha_lo");
        rd_check(3'd5, 32'hC0A80101, "t1_tpa");
        rd_check(3'd6, 32'h00000001, "t1_type_rd");
        pulse_ack();
        check_eq("t1_ack_valid", {31'h0, pkt_valid}, 32'h0);
        rd_check(3'd2, 32'hC0A8010A, "t1_bank_kept");

        // Unicast reply
        build_arp(MY_MAC, 16'h0806, 16'h0002, SHA_B, 32'hC0A80114, MY_MAC, 32'hC0A80105, 60);
        send_frame(1'b1, 1'b0);
        check_eq("t2_valid", {31'h0, pkt_valid}, 32'h1);
        check_eq("t2_type", {30'h0, pkt_type}, 32'h2);
        rd_check(3'd3, 32'h02005E10, "t2_tha_hi");
        rd_check(3'd4, 32'h20300000, "t2_tha_lo");
        rd_check(3'd5, 32'hC0A80105, "t2_tpa");
        pulse_ack();
        check_eq("t2_ack_valid", {31'h0, pkt_valid}, 32'h0);
        check_eq("t2_ack_type", {30'h0, pkt_type}, 32'h0);
        rd_check(3'd3, 32'h02005E10, "t2_bank_kept");

        // Corrupted FCS
        build_arp(BCAST, 16'h0806, 16'h0001, SHA_A, 32'hC0A8010A, 48'h0, 32'hC0A80101, 60);
        frm[63] = frm[63] ^ 8'h01;
        send_frame(1'b0, 1'b0);
        check_eq("t3_valid", {31'h0, pkt_valid}, 32'h0);
        rd_check(3'd7, 32'h00000001, "t3_drop");

        // Wrong destination MAC, wrong ethertype, runt, oversize
        build_arp(48'h02_00_5E_10_20_31, 16'h0806, 16'h0001, SHA_A, 32'hC0A8010A, 48'h0, 32'hC0A80101, 60);
        send_frame(1'b0, 1'b0);
        rd_check(3'd7, 32'h00000002, "t4_drop_mac");
        build_arp(BCAST, 16'h0800, 16'h0001, SHA_A, 32'hC0A8010A, 48'h0, 32'hC0A80101, 60);
        send_frame(1'b0, 1'b0);
        rd_check(3'd7, 32'h00000003, "t4_drop_etype");
        check_eq("t4_valid", {31'h0, pkt_valid}, 32'h0);
        rd_check(3'd2, 32'hC0A80114, "t4_no_capture");
        build_arp(BCAST, 16'h0806, 16'h0001, SHA_A, 32'hC0A8010A, 48'h0, 32'hC0A80101, 59);
        send_frame(1'b0, 1'b0);
        rd_check(3'd7, 32'h00000004, "t4_drop_runt");
        build_arp(BCAST, 16'h0806, 16'h0001, SHA_A, 32'hC0A8010A, 48'h0, 32'hC0A80101, 1515);
        send_frame(1'b0, 1'b0);
        rd_check(3'd7, 32'h00000005, "t4_drop_oversize");

        // Exactly maximum length is accepted
        build_arp(BCAST, 16'h0806, 16'h0001, SHA_A, 32'hC0A80163, 48'h0, 32'hC0A80101, 1514);
        send_frame(1'b1, 1'b0);
        check_eq("tmax_valid", {31'h0, pkt_valid}, 32'h1);
        rd_check(3'd2, 32'hC0A80163, "tmax_spa");
        pulse_ack();

        // Overflow while holding, then ack coinciding with a capture
        build_arp(BCAST, 16'h0806, 16'h0001, SHA_A, 32'hC0A8010A, 48'h0, 32'hC0A80101, 60);
        send_frame(1'b1, 1'b0);
        build_arp(MY_MAC, 16'h0806, 16'h0002, SHA_B, 32'hC0A80114, MY_MAC, 32'hC0A80105, 60);
        send_frame(1'b0, 1'b0);
        check_eq("t5_valid", {31'h0, pkt_valid}, 32'h1);
        check_eq("t5_type", {30'h0, pkt_type}, 32'h1);
        rd_check(3'd2, 32'hC0A8010A, "t5_first_kept");
        rd_check(3'd7, 32'h00000105, "t5_ovf");
        pulse_ack();
        check_eq("t5_ack_valid", {31'h0, pkt_valid}, 32'h0);
        send_frame(1'b1, 1'b1);
        check_eq("t5_commit_wins", {31'h0, pkt_valid}, 32'h1);
        check_eq("t5_type2", {30'h0, pkt_type}, 32'h2);
        rd_check(3'd2, 32'hC0A80114, "t5_spa2");

        // Reset in the middle of the header
        build_arp(BCAST, 16'h0806, 16'h0001, SHA_A, 32'hC0A8010A, 48'h0, 32'hC0A80101, 60);
        for (int i = 0; i < 7; i++) drive_byte(8'h55);
        drive_byte(8'hD5);
        for (int i = 0; i < 20; i++) drive_byte(frm[i]);
        @(posedge rx_clk); #1;
        rst_n   = 1'b0;
        rx_data = frm[20];
        @(negedge rx_clk);
        check_eq("t6_rst_valid", {31'h0, pkt_valid}, 32'h0);
        check_eq("t6_rst_type", {30'h0, pkt_type}, 32'h0);
        check_eq("t6_rst_stb", {31'h0, pkt_stb}, 32'h0);
        rd_check(3'd7, 32'h0, "t6_rst_counters");
        rd_check(3'd2, 32'h0, "t6_rst_spa");
        @(posedge rx_clk); #1;
        rst_n = 1'b1;
        for (int i = 21; i < 64; i++) drive_byte(frm[i]);
        @(posedge rx_clk); #1;
        rx_dv = 1'b0;
        repeat (3) @(posedge rx_clk);
        @(negedge rx_clk);
        check_eq("t6_tail_valid", {31'h0, pkt_valid}, 32'h0);
        rd_check(3'd7, 32'h0, "t6_tail_no_drop");
        frame_no++;
        $display("frame %0d: reset mid-header", frame_no);
        send_frame(1'b1, 1'b0);
        check_eq("t6_valid", {31'h0, pkt_valid}, 32'h1);
        check_eq("t6_type", {30'h0, pkt_type}, 32'h1);
        rd_check(3'd2, 32'hC0A8010A, "t6_spa");
        pulse_ack();

        // Drop counter wrap
        for (int n = 0; n < 255; n++) send_short_bad();
        @(negedge rx_clk);
        rd_check(3'd7, 32'h000000FF, "wrap_ff");
        send_short_bad();
        @(negedge rx_clk);
        rd_check(3'd7, 32'h00000000, "wrap_00");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
